// File: rtl/ysyx_pkg.sv
// Shared LSU package: FSM state encoding, RV32 funct3 size codes and strobe/alignment helpers.
package ysyx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_STORE = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Only the size bits matter; unused codes 011/110/111 fall through to word.
   function automatic logic [7:0] size_strb(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   size_strb = 8'h01;
         2'b01:   size_strb = 8'h03;
         default: size_strb = 8'h0f;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3[1:0])
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = addr_lo[0];
         default: is_misaligned = (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/ysyx_lsu_if.sv
// LSU bundle: EXU request, WBU response and the load/store bus toward the arbiter.
interface ysyx_lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [2:0]        req_funct3;
   logic [4:0]        req_rd;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic [4:0]        rsp_rd;
   logic              rsp_err;

   logic [ADDR_W-1:0] lsu_araddr;
   logic              lsu_arvalid;
   logic [7:0]        lsu_rstrb;
   logic [DATA_W-1:0] lsu_rdata;
   logic              lsu_rvalid;

   logic [ADDR_W-1:0] lsu_awaddr;
   logic              lsu_awvalid;
   logic [DATA_W-1:0] lsu_wdata;
   logic [7:0]        lsu_wstrb;
   logic              lsu_wvalid;
   logic              lsu_wready;

   modport master (
      input  req_valid, req_wen, req_addr, req_wdata, req_funct3, req_rd,
      input  rsp_ready, lsu_rdata, lsu_rvalid, lsu_wready,
      output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
      output lsu_araddr, lsu_arvalid, lsu_rstrb,
      output lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid
   );

   modport slave (
      output req_valid, req_wen, req_addr, req_wdata, req_funct3, req_rd,
      output rsp_ready, lsu_rdata, lsu_rvalid, lsu_wready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
      input  lsu_araddr, lsu_arvalid, lsu_rstrb,
      input  lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid
   );
endinterface

// File: rtl/ysyx_lsu_ext.sv
// Combinational load-data extender: picks the low byte/halfword and sign- or zero-extends it.
module ysyx_lsu_ext
   import ysyx_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        funct3_i,
   input  logic [DATA_W-1:0] raw_i,
   output logic [DATA_W-1:0] data_o
);

   always_comb begin
      data_o = raw_i;
      case (funct3_i)
         F3_B:    data_o = {{(DATA_W-8){raw_i[7]}}, raw_i[7:0]};
         F3_H:    data_o = {{(DATA_W-16){raw_i[15]}}, raw_i[15:0]};
         F3_BU:   data_o = {{(DATA_W-8){1'b0}}, raw_i[7:0]};
         F3_HU:   data_o = {{(DATA_W-16){1'b0}}, raw_i[15:0]};
         default: data_o = raw_i;
      endcase
   end

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: one outstanding access, IDLE -> LOAD/STORE -> RESP with registered bus and response outputs.
// Optional macro YSYX_LSU_MISALIGN_CHK_EN short-circuits misaligned H/W accesses to an error response.
module ysyx_lsu
   import ysyx_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   ysyx_lsu_if.master    io
);

   lsu_state_e        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [2:0]        funct3_q;
   logic [4:0]        rd_q;
   logic              arvalid_q;
   logic              awvalid_q;
   logic              rsp_valid_q;
   logic              err_q;
   logic [DATA_W-1:0] ext_data;
   logic              misalign;

   ysyx_lsu_ext #(.DATA_W(DATA_W)) u_ext (
      .funct3_i (funct3_q),
      .raw_i    (io.lsu_rdata),
      .data_o   (ext_data)
   );

`ifdef YSYX_LSU_MISALIGN_CHK_EN
   assign misalign = is_misaligned(io.req_funct3, io.req_addr[1:0]);
`else
   assign misalign = 1'b0;
`endif

   // Bus valids are set on entry to LOAD/STORE and cleared on completion, so they never overlap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         funct3_q    <= '0;
         rd_q        <= '0;
         arvalid_q   <= 1'b0;
         awvalid_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (io.req_valid) begin
                  addr_q   <= io.req_addr;
                  wdata_q  <= io.req_wdata;
                  funct3_q <= io.req_funct3;
                  rd_q     <= io.req_rd;
                  rdata_q  <= '0;
                  err_q    <= misalign;
                  if (misalign) begin
                     rsp_valid_q <= 1'b1;
                     state_q     <= ST_RESP;
                  end else if (io.req_wen) begin
                     awvalid_q <= 1'b1;
                     state_q   <= ST_STORE;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (io.lsu_rvalid) begin
                  rdata_q     <= ext_data;
                  arvalid_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_STORE: begin
               if (io.lsu_wready) begin
                  awvalid_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (io.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign io.req_ready   = (state_q == ST_IDLE);
   assign io.lsu_araddr  = addr_q;
   assign io.lsu_arvalid = arvalid_q;
   assign io.lsu_rstrb   = size_strb(funct3_q);
   assign io.lsu_awaddr  = addr_q;
   assign io.lsu_awvalid = awvalid_q;
   assign io.lsu_wvalid  = awvalid_q;
   assign io.lsu_wdata   = wdata_q;
   assign io.lsu_wstrb   = size_strb(funct3_q);
   assign io.rsp_valid   = rsp_valid_q;
   assign io.rsp_rdata   = rdata_q;
   assign io.rsp_rd      = rd_q;
   assign io.rsp_err     = err_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Self-checking bench for ysyx_lsu: directed vector table, randomized transactions against a
// size/sign reference model, and reset/misalignment sequences.
module tb_ysyx_lsu;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   ysyx_lsu_if #(.ADDR_W(32), .DATA_W(32)) io ();

   ysyx_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .io     (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] busData;
      int          busDelay;
      int          rspDelay;
      logic [31:0] expData;
      logic [7:0]  expStrb;
   } vec_t;

   vec_t vecs[9];

   // Reference model: access size in bytes from the low funct3 bits.
   function automatic int refSize(input logic [2:0] f3);
      int code;
      code = int'(f3) % 4;
      if (code == 0) return 1;
      if (code == 1) return 2;
      return 4;
   endfunction

   function automatic logic [7:0] refStrb(input logic [2:0] f3);
      int v;
      v = (1 << refSize(f3)) - 1;
      return v[7:0];
   endfunction

   function automatic logic [31:0] refExtend(input logic [2:0] f3, input logic [31:0] raw);
      longint lim;
      longint v;
      int     sz;
      sz = refSize(f3);
      if (sz == 4) return raw;
      lim = longint'(1) << (8 * sz);
      v = longint'(raw) % lim;
      if (f3 < 3'd4 && v >= lim / 2) v = v - lim;
      return v[31:0];
   endfunction

   function automatic logic refMisaligned(input logic [2:0] f3, input logic [31:0] addr);
      return (longint'(addr) % refSize(f3)) != 0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] busData,
                                input int busDelay, input int rspDelay, input logic [31:0] expData,
                                input logic [7:0] expStrb, input logic expErr);
      checkOutput("idle_req_ready", io.req_ready, 1);
      io.req_valid  = 1'b1;
      io.req_wen    = wen;
      io.req_addr   = addr;
      io.req_wdata  = wdata;
      io.req_funct3 = f3;
      io.req_rd     = rd;
      tick();
      io.req_valid  = 1'b0;
      io.req_addr   = $urandom;
      io.req_wdata  = $urandom;
      io.req_funct3 = 3'($urandom_range(0, 7));
      io.req_rd     = 5'($urandom_range(0, 31));
      if (!expErr) begin
         for (int c = 0; c <= busDelay; c++) begin
            if (c == busDelay) begin
               io.lsu_rvalid = !wen;
               io.lsu_wready = wen;
               io.lsu_rdata  = busData;
            end else begin
               io.lsu_rvalid = wen ? 1'($urandom_range(0, 1)) : 1'b0;
               io.lsu_wready = wen ? 1'b0 : 1'($urandom_range(0, 1));
               io.lsu_rdata  = $urandom;
            end
            checkOutput("bus_arvalid", io.lsu_arvalid, 32'(!wen));
            checkOutput("bus_awvalid", io.lsu_awvalid, 32'(wen));
            checkOutput("bus_wvalid", io.lsu_wvalid, 32'(wen));
            checkOutput("bus_rsp_valid", io.rsp_valid, 0);
            checkOutput("bus_req_ready", io.req_ready, 0);
            if (wen) begin
               checkOutput("awaddr", io.lsu_awaddr, addr);
               checkOutput("wdata", io.lsu_wdata, wdata);
               checkOutput("wstrb", 32'(io.lsu_wstrb), 32'(expStrb));
            end else begin
               checkOutput("araddr", io.lsu_araddr, addr);
               checkOutput("rstrb", 32'(io.lsu_rstrb), 32'(expStrb));
            end
            tick();
         end
         io.lsu_rvalid = 1'b0;
         io.lsu_wready = 1'b0;
         io.lsu_rdata  = $urandom;
      end
      io.rsp_ready = 1'b0;
      for (int c = 0; c <= rspDelay; c++) begin
         if (c == rspDelay) io.rsp_ready = 1'b1;
         checkOutput("rsp_valid", io.rsp_valid, 1);
         checkOutput("rsp_rdata", io.rsp_rdata, expData);
         checkOutput("rsp_rd", 32'(io.rsp_rd), 32'(rd));
         checkOutput("rsp_err", 32'(io.rsp_err), 32'(expErr));
         checkOutput("rsp_req_ready", io.req_ready, 0);
         checkOutput("rsp_arvalid", io.lsu_arvalid, 0);
         checkOutput("rsp_awvalid", io.lsu_awvalid, 0);
         tick();
      end
      io.rsp_ready = 1'b0;
      checkOutput("done_rsp_valid", io.rsp_valid, 0);
   endtask

   initial begin
      logic        wen;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] raw;
      logic        err;
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      io.req_valid  = 1'b0;
      io.req_wen    = 1'b0;
      io.req_addr   = '0;
      io.req_wdata  = '0;
      io.req_funct3 = '0;
      io.req_rd     = '0;
      io.rsp_ready  = 1'b0;
      io.lsu_rdata  = '0;
      io.lsu_rvalid = 1'b0;
      io.lsu_wready = 1'b0;

      vecs[0] = '{1'b0, 32'h8000_0003, 32'h0, 3'b000, 5'd1, 32'h0000_0080, 3, 0, 32'hFFFF_FF80, 8'h01};
      vecs[1] = '{1'b0, 32'h8000_0002, 32'h0, 3'b101, 5'd2, 32'h0000_8001, 1, 0, 32'h0000_8001, 8'h03};
      vecs[2] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'b010, 5'd3, 32'h0, 5, 0, 32'h0, 8'h0f};
      vecs[3] = '{1'b0, 32'h8000_0000, 32'h0, 3'b010, 5'd4, 32'h1234_5678, 0, 4, 32'h1234_5678, 8'h0f};
      vecs[4] = '{1'b0, 32'h8000_0000, 32'h0, 3'b001, 5'd5, 32'hABCD_8765, 2, 1, 32'hFFFF_8765, 8'h03};
      vecs[5] = '{1'b0, 32'h8000_0001, 32'h0, 3'b100, 5'd6, 32'hFFFF_FFF0, 1, 0, 32'h0000_00F0, 8'h01};
      vecs[6] = '{1'b1, 32'h8000_0005, 32'h1122_3344, 3'b000, 5'd7, 32'h0, 0, 2, 32'h0, 8'h01};
      vecs[7] = '{1'b0, 32'h8000_0004, 32'h0, 3'b111, 5'd8, 32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D, 8'h0f};
      vecs[8] = '{1'b1, 32'h8000_0006, 32'h0000_A5A5, 3'b001, 5'd31, 32'h0, 2, 0, 32'h0, 8'h03};

      tick();
      checkOutput("rst_arvalid", io.lsu_arvalid, 0);
      checkOutput("rst_awvalid", io.lsu_awvalid, 0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("rst_req_ready", io.req_ready, 1);
      checkOutput("rst_rsp_valid", io.rsp_valid, 0);
      checkOutput("rst_wvalid", io.lsu_wvalid, 0);
      checkOutput("rst_rsp_rdata", io.rsp_rdata, 0);
      checkOutput("rst_rsp_rd", 32'(io.rsp_rd), 0);
      checkOutput("rst_rsp_err", 32'(io.rsp_err), 0);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].f3, vecs[i].rd,
                       vecs[i].busData, vecs[i].busDelay, vecs[i].rspDelay,
                       vecs[i].expData, vecs[i].expStrb, 1'b0);
      end

      for (int i = 0; i < 40; i++) begin
         wen  = 1'($urandom_range(0, 1));
         f3   = wen ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         addr = $urandom;
         raw  = $urandom;
`ifdef YSYX_LSU_MISALIGN_CHK_EN
         err = refMisaligned(f3, addr);
`else
         err = 1'b0;
`endif
         applyStimulus(wen, addr, $urandom, f3, 5'($urandom_range(0, 31)), raw,
                       $urandom_range(0, 4), $urandom_range(0, 2),
                       (wen || err) ? 32'h0 : refExtend(f3, raw), refStrb(f3), err);
      end

`ifdef YSYX_LSU_MISALIGN_CHK_EN
      applyStimulus(1'b0, 32'h8000_0002, 32'h0, 3'b010, 5'd9, 32'h5555_5555, 0, 0,
                    32'h0, 8'h0f, 1'b1);
`endif

      // Reset in the middle of a load must drop the access and never produce a response.
      io.req_valid  = 1'b1;
      io.req_wen    = 1'b0;
      io.req_addr   = 32'h8000_0100;
      io.req_funct3 = 3'b010;
      io.req_rd     = 5'd7;
      tick();
      io.req_valid = 1'b0;
      checkOutput("midrst_arvalid_before", io.lsu_arvalid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_arvalid_now", io.lsu_arvalid, 0);
      checkOutput("midrst_req_ready", io.req_ready, 1);
      checkOutput("midrst_rsp_rd", 32'(io.rsp_rd), 0);
      tick();
      rst_n = 1'b1;
      io.lsu_rvalid = 1'b1;
      io.lsu_rdata  = 32'h0BAD_0BAD;
      io.lsu_wready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput("midrst_no_rsp", io.rsp_valid, 0);
         checkOutput("midrst_no_arvalid", io.lsu_arvalid, 0);
         checkOutput("midrst_idle", io.req_ready, 1);
         checkOutput("midrst_rdata", io.rsp_rdata, 0);
      end
      io.lsu_rvalid = 1'b0;
      io.lsu_wready = 1'b0;
      tick();
      applyStimulus(1'b0, 32'h8000_0200, 32'h0, 3'b000, 5'd12, 32'h0000_007F, 1, 0,
                    32'h0000_007F, 8'h01, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_lsu.md
YSYX_LSU -- requirements
Module: ysyx_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 clk  in  1  sole clock, all state on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req_valid/req_ready  in/out  1  EXU request handshake.
REQ-006 req_wen  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  ADDR_W  byte address.
REQ-008 req_wdata  in  DATA_W  store data, unshifted.
REQ-009 req_funct3  in  3  RV32 size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-010 req_rd  in  5  destination register tag.
REQ-011 rsp_valid/rsp_ready  out/in  1  response handshake to WBU.
REQ-012 rsp_rdata  out  DATA_W  extended load data, 0 for stores.
REQ-013 rsp_rd  out  5  tag echoed from request.
REQ-014 rsp_err  out  1  misaligned-access flag.
REQ-015 lsu_araddr, lsu_arvalid, lsu_rstrb  out  ADDR_W/1/8  load request to bus arbiter.
REQ-016 lsu_rdata, lsu_rvalid  in  DATA_W/1  load return, already right-aligned by arbiter.
REQ-017 lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid  out  ADDR_W/1/DATA_W/8/1  store request.
REQ-018 lsu_wready  in  1  store completion.

Function
REQ-019 SHALL implement FSM IDLE, LOAD, STORE, RESP; req_ready = 1 only in IDLE.
REQ-020 On req_valid & req_ready SHALL latch addr, wdata, funct3, rd, wen; go LOAD (wen=0) or STORE (wen=1).
REQ-021 In LOAD SHALL hold lsu_arvalid=1 and lsu_araddr stable until lsu_rvalid=1, then capture data and go RESP.
REQ-022 lsu_rstrb SHALL be 8'h01 (B/BU), 8'h03 (H/HU), 8'h0f (W); funct3 011/110/111 treated as W.
REQ-023 Load data SHALL be sign-extended for B/H, zero-extended for BU/HU, taken from low byte/halfword.
REQ-024 In STORE SHALL hold lsu_awvalid=lsu_wvalid=1, stable addr/data, lsu_wstrb per REQ-022 (funct3[1:0] only), until lsu_wready=1, then go RESP.
REQ-025 lsu_wdata SHALL be req_wdata unshifted; byte-lane shift belongs to the arbiter.
REQ-026 In RESP SHALL assert rsp_valid, hold rsp_* stable until rsp_ready=1, then go IDLE.
REQ-027 Minimum latency: request accept to rsp_valid = bus response cycle + 1; back-to-back requests SHALL have one IDLE cycle between.
REQ-028 lsu_arvalid and lsu_awvalid SHALL never be high simultaneously.
REQ-029 lsu_rvalid outside LOAD and lsu_wready outside STORE SHALL be ignored.
REQ-030 All bus valid outputs SHALL be 0 in IDLE and RESP.

Reset
REQ-031 rst low SHALL immediately force IDLE, all valids 0, req_ready 1 after release, rsp_rdata/rsp_rd/rsp_err 0.
REQ-032 Reset mid-LOAD/STORE SHALL abandon the transaction; no response emitted.

Configuration
REQ-033 Macro YSYX_LSU_MISALIGN_CHK_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL go IDLE->RESP directly, rsp_err=1, rsp_rdata=0, no bus valid asserted.
REQ-034 Macro undefined: no check, all accesses issued to bus, rsp_err tied 0.

Structure
REQ-035 FSM state encoding and funct3 constants SHALL live in shared package ysyx_pkg (or ysyx_macro.v defines).
REQ-036 Load extension SHALL be sub-module ysyx_lsu_ext (funct3, raw data -> extended data), purely combinational.

Verification
REQ-037 LB addr 0x8000_0003, lsu_rdata 0x0000_0080 after 3 cycles -> rsp_rdata 0xFFFF_FF80, rstrb 0x01.
REQ-038 LHU addr 0x8000_0002, lsu_rdata 0x0000_8001 -> rsp_rdata 0x0000_8001, rstrb 0x03.
REQ-039 SW addr 0x8000_0010 data 0xDEAD_BEEF, wready delayed 5 cycles -> aw/wvalid held 5 cycles stable, wstrb 0x0f, then rsp_valid.
REQ-040 Load completes with rsp_ready=0 for 4 cycles -> rsp_valid/rsp_rdata stable, req_ready 0 throughout.
REQ-041 rst low during LOAD with arvalid=1 -> arvalid 0 same cycle, no rsp_valid after release.
REQ-042 With YSYX_LSU_MISALIGN_CHK_EN, LW addr 0x8000_0002 -> rsp_err 1 next cycle, arvalid never asserted.
